systolic_feeder: RTL and testbench

Input-side sequencer for the systolic array. It accepts weight vectors and feature vectors from the on-chip buffers over valid/ready handshakes. It drives the array's weight-load port (`weight_input2`, `weight_en`) and its skewed feature port (`feature_input2`, `in_en`), and issues the one-cycle `conv_ctrl` start pulse to the array's convolution controller. Feature rows are staggered so that row r reaches the array r cycles after row 0, which is the diagonal wavefront the array consumes.

---
 rtl/systolic_feeder.sv | 176 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Input-side sequencer for the systolic array: loads `row` weight vectors, then streams
// feature vectors through per-row skew chains so row r reaches the array r cycles late.
module systolic_feeder #(
    parameter int width = 8,
    parameter int row   = 4,
    parameter int col   = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [7:0]       vec_count,
    input  logic [width-1:0] w_data [col-1:0],
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [width-1:0] f_data [row-1:0],
    input  logic             f_valid,
    output logic             f_ready,
    output logic [width-1:0] weight_input2 [col-1:0],
    output logic             weight_en,
    output logic [width-1:0] feature_input2 [row-1:0],
    output logic             in_en [row-1:0],
    output logic             conv_ctrl,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(row - 1);

    state_t           r_state;
    logic [7:0]       r_count;
    logic [7:0]       r_cnt;
    logic [width-1:0] r_weight [col-1:0];
    logic             r_weight_en;
    logic             r_conv_ctrl;
    logic             r_busy;
    logic             r_done;
    logic             w_f_accept;

    // Handshake readies decode the state register only.
    always_comb begin
        w_ready = 1'b0;
        f_ready = 1'b0;
        case (r_state)
            S_LOAD_W: w_ready = 1'b1;
            S_STREAM: f_ready = 1'b1;
            default: begin
                w_ready = 1'b0;
                f_ready = 1'b0;
            end
        endcase
    end

    assign w_f_accept = (r_state == S_STREAM) && f_valid;

    // Pass sequencer; r_cnt is shared by weight beats, feature beats and drain cycles.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state     <= S_IDLE;
            r_count     <= 8'd0;
            r_cnt       <= 8'd0;
            r_weight_en <= 1'b0;
            r_conv_ctrl <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int c = 0; c < col; c++) begin
                r_weight[c] <= {width{1'b0}};
            end
        end else begin
            r_weight_en <= 1'b0;
            r_conv_ctrl <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count <= vec_count;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        r_weight    <= w_data;
                        r_weight_en <= 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            r_cnt <= 8'd0;
                            if (r_count != 8'd0) begin
                                r_conv_ctrl <= 1'b1;
                                r_state     <= S_STREAM;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_STREAM: begin
                    if (f_valid) begin
                        // Exact-equality compare: the counter stops before it could wrap.
                        if ((r_cnt + 8'd1) == r_count) begin
                            r_cnt   <= 8'd0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == LAST_IDX) begin
                        r_cnt   <= 8'd0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign weight_input2 = r_weight;
    assign weight_en     = r_weight_en;
    assign conv_ctrl     = r_conv_ctrl;
    assign busy          = r_busy;
    assign done          = r_done;

    for (genvar r = 0; r < row; r++) begin : g_chain
        logic             r_v [0:r];
        logic [width-1:0] r_d [0:r];

        // Skew chain of depth r+1; data stages load only behind a valid stage so the
        // tail holds its last value across bubbles.
        always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
                for (int k = 0; k <= r; k++) begin
                    r_v[k] <= 1'b0;
                    r_d[k] <= {width{1'b0}};
                end
            end else begin
                r_v[0] <= w_f_accept;
                if (w_f_accept) begin
                    r_d[0] <= f_data[r];
                end
                for (int k = 1; k <= r; k++) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_d[k] <= r_d[k-1];
                    end
                end
            end
        end

        assign in_en[r]          = r_v[r];
        assign feature_input2[r] = r_d[r];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table of passes, event scoreboard checked every cycle.
module tb_systolic_feeder;
    localparam int W = 8;
    localparam int R = 4;
    localparam int C = 4;

    localparam int K_WEN  = 0;
    localparam int K_CONV = 1;
    localparam int K_DONE = 2;
    localparam int K_INEN = 3;
    localparam int K_WRDY = 4;
    localparam int K_FRDY = 5;
    localparam int K_BUSY = 6;

    logic         clk       = 1'b0;
    logic         nrst      = 1'b1;
    logic         start     = 1'b0;
    logic [7:0]   vec_count = 8'd0;
    logic         w_valid   = 1'b0;
    logic         f_valid   = 1'b0;
    logic [W-1:0] w_data [C-1:0];
    logic [W-1:0] f_data [R-1:0];
    logic         w_ready, f_ready, weight_en, conv_ctrl, busy, done;
    logic [W-1:0] weight_input2 [C-1:0];
    logic [W-1:0] feature_input2 [R-1:0];
    logic         in_en [R-1:0];

    typedef struct {
        int cyc;
        int kind;
        int idx;
        int d;
    } ev_t;

    typedef struct {
        int          vec;
        logic [15:0] fpat;
        int          wbase;
        int          done_off;
        int          abort;
    } pass_t;

    ev_t sb[$];
    int  cyc      = 0;
    int  n_assert = 0;
    int  n_fail   = 0;
    int  last_w [C];
    int  last_f [R];

    systolic_feeder #(.width(W), .row(R), .col(C)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start          (start),
        .vec_count      (vec_count),
        .w_data         (w_data),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .f_data         (f_data),
        .f_valid        (f_valid),
        .f_ready        (f_ready),
        .weight_input2  (weight_input2),
        .weight_en      (weight_en),
        .feature_input2 (feature_input2),
        .in_en          (in_en),
        .conv_ctrl      (conv_ctrl),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input int k, input int i, input int d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.idx  = i;
        e.d    = d;
        sb.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, idx, cyc, act, exp);
        end
    endtask

    // Scoreboard: pop this cycle's expected events and compare every output
    always @(negedge clk) begin : mon
        int e_wen, e_conv, e_done, e_wr, e_fr, e_busy;
        int e_en [R];
        e_wen = 0; e_conv = 0; e_done = 0; e_wr = 0; e_fr = 0; e_busy = 0;
        for (int r = 0; r < R; r++) e_en[r] = 0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_WEN:  begin e_wen = 1; last_w[sb[i].idx] = sb[i].d; end
                    K_CONV: e_conv = 1;
                    K_DONE: e_done = 1;
                    K_INEN: begin e_en[sb[i].idx] = 1; last_f[sb[i].idx] = sb[i].d; end
                    K_WRDY: e_wr = 1;
                    K_FRDY: e_fr = 1;
                    K_BUSY: e_busy = 1;
                    default: ;
                endcase
                sb.delete(i);
            end
        end
        chk("weight_en", 0, int'(weight_en), e_wen);
        chk("conv_ctrl", 0, int'(conv_ctrl), e_conv);
        chk("done", 0, int'(done), e_done);
        chk("busy", 0, int'(busy), e_busy);
        chk("w_ready", 0, int'(w_ready), e_wr);
        chk("f_ready", 0, int'(f_ready), e_fr);
        for (int c = 0; c < C; c++) chk("weight_input2", c, int'(weight_input2[c]), last_w[c]);
        for (int r = 0; r < R; r++) begin
            chk("in_en", r, int'(in_en[r]), e_en[r]);
            chk("feature_input2", r, int'(feature_input2[r]), last_f[r]);
        end
    end

    task automatic do_reset(input int ncyc);
        nrst    = 1'b1;
        start   = 1'b0;
        w_valid = 1'b0;
        f_valid = 1'b0;
        sb.delete();
        for (int c = 0; c < C; c++) last_w[c] = 0;
        for (int r = 0; r < R; r++) last_f[r] = 0;
        repeat (ncyc) @(posedge clk);
        #1;
        nrst = 1'b0;
    endtask

    task automatic run_pass(input pass_t p);
        int p0, acc, j;
        @(posedge clk);
        #1;
        p0        = cyc;
        start     = 1'b1;
        vec_count = 8'(p.vec);
        for (int c = 1; c <= p.done_off; c++) push(p0 + c, K_BUSY, 0, 0);
        push(p0 + p.done_off, K_DONE, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < R; k++) begin
            start     = (k == 1);
            vec_count = (k == 1) ? 8'd99 : 8'(p.vec);
            w_valid   = 1'b1;
            for (int c = 0; c < C; c++) begin
                w_data[c] = 8'(p.wbase + 16 * c + k + 1);
                push(cyc + 1, K_WEN, c, p.wbase + 16 * c + k + 1);
            end
            push(cyc, K_WRDY, 0, 0);
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        w_valid = 1'b0;
        if (p.vec > 0) push(cyc, K_CONV, 0, 0);
        acc = 0;
        j   = 0;
        while (acc < p.vec && j < 16) begin
            push(cyc, K_FRDY, 0, 0);
            f_valid = p.fpat[j];
            for (int r = 0; r < R; r++) begin
                if (p.fpat[j]) begin
                    f_data[r] = 8'(10 * (acc + 1) + r);
                    push(cyc + 1 + r, K_INEN, r, 10 * (acc + 1) + r);
                end else begin
                    f_data[r] = 8'hEE;
                end
            end
            if (p.fpat[j]) acc++;
            j++;
            @(posedge clk);
            #1;
            if (p.abort >= 0 && acc == p.abort) begin
                do_reset(3);
                return;
            end
        end
        f_valid = 1'b0;
        while (cyc <= p0 + p.done_off + 1) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", 0, sb.size(), 0);
    endtask

    pass_t tbl [7];

    initial begin
        // vec, f_valid pattern (bit j = stream cycle j), weight base, start->done offset, abort beat
        tbl[0] = '{vec: 2, fpat: 16'hFFFF, wbase: 0,   done_off: 11, abort: -1};
        tbl[1] = '{vec: 3, fpat: 16'hFFFF, wbase: 32,  done_off: 12, abort: -1};
        tbl[2] = '{vec: 2, fpat: 16'h0005, wbase: 64,  done_off: 12, abort: -1};
        tbl[3] = '{vec: 0, fpat: 16'h0000, wbase: 96,  done_off: 5,  abort: -1};
        tbl[4] = '{vec: 5, fpat: 16'h00D3, wbase: 128, done_off: 17, abort: -1};
        tbl[5] = '{vec: 3, fpat: 16'hFFFF, wbase: 160, done_off: 12, abort: 1};
        tbl[6] = '{vec: 2, fpat: 16'hFFFF, wbase: 192, done_off: 11, abort: -1};
        for (int c = 0; c < C; c++) w_data[c] = 8'd0;
        for (int r = 0; r < R; r++) f_data[r] = 8'd0;
        do_reset(3);
        for (int i = 0; i < 7; i++) run_pass(tbl[i]);
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
